fixed_point_div: RTL and testbench
==================================

# fixed_point_div

Sequential signed fixed-point divider: the division counterpart to the fixed-point package's add, subtract and mult functions, implemented as a clocked block rather than a function. It accepts a dividend/divisor pair over a valid/ready handshake and computes one quotient bit per cycle by restoring division on magnitudes. It then drives a saturated, sign-corrected quotient in the same Q format on an output valid/ready handshake. It sits wherever datapaths need a fixed-point divide that cannot be a combinational expression.

## Interface
- WIDTH, 32: total operand/result width including sign bit (M = WIDTH-1-Q integer bits).
- Q, 16: fractional bits; 0 <= Q <= WIDTH-2.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- dividend  input  WIDTH  signed, right-justified, Q fractional bits.
- divisor  input  WIDTH  signed, same format.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  signed result, same format.
- overflow  output  1  quotient saturated (valid with out_valid).
- div_by_zero  output  1  divisor was zero (valid with out_valid).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, capture the operand signs, |dividend| and |divisor|, each as WIDTH-bit magnitudes (so the most-negative value is representable). Clear the bit counter. Go to CALC.
- Numerator = |dividend| << Q (WIDTH+Q bits). ITER = WIDTH+Q.
- CALC: one restoring step per cycle, MSB first. Shift the remainder in with the next numerator bit. If remainder >= |divisor|, subtract and set the quotient bit. After step ITER, go to FIX.
- FIX: neg = sign(dividend) XOR sign(divisor).
  - If divisor == 0: div_by_zero=1, overflow=0. Quotient = 2^(WIDTH-1)-1 if dividend >= 0, else -2^(WIDTH-1).
  - Else if magnitude > 2^(WIDTH-1)-1 (neg=0) or > 2^(WIDTH-1) (neg=1): overflow=1 and saturate to max or min.
  - Else quotient = neg ? -mag : mag.
  - Rounding is truncation toward zero. Go to DONE.
- DONE: out_valid=1; quotient and flags held stable. On out_valid && out_ready, go to IDLE.
- Divide-by-zero still runs the full CALC sequence, so latency is constant.
- in_ready=0 outside IDLE. Input changes after acceptance are ignored.

## Timing
- Reset (async assert, sync-safe deassert by design): state=IDLE, in_ready=1, out_valid=0, quotient=0, overflow=0, div_by_zero=0, internal registers zero.
- Accept at edge k:
  - CALC steps occur on edges k+1 .. k+ITER.
  - FIX registers outputs on edge k+ITER+1.
  - out_valid is high from edge k+ITER+1 onward. Default latency is 49 edges.
- Output handshake at edge j → IDLE. in_ready=1 from edge j. Next accept is no earlier than edge j+1. Throughput is one op per ITER+3 cycles minimum.
- out_ready held low: DONE persists indefinitely with outputs stable.
- out_ready high while not in DONE: no effect.
- rst_n asserted mid-CALC/FIX/DONE: immediate return to reset values; the in-flight operation is discarded and produces no output.

## Structure
- Add to package fixed_point: enum typedef fixed_point_div_state_t {IDLE, CALC, FIX, DONE}.
- Add to package fixed_point: functions sat_max(width) and sat_min(width) returning signed saturation limits, for reuse by mult saturation later.
- Single module; no sub-module is natural. The restore step is one subtract/compare, kept inline.

## Test plan (WIDTH=32, Q=16)
- 0x00018000 / 0x00008000 (1.5/0.5) → quotient 0x00030000, flags 0, out_valid exactly 49 edges after accept.
- 0x00010000 / 0x00030000 → 0x00005555; 0xFFFF0000 / 0x00030000 → 0xFFFFAAAB (truncation toward zero).
- 0x7FFF0000 / 0x00008000 → 0x7FFFFFFF, overflow=1. 0x80000000 / 0xFFFF0000 → 0x7FFFFFFF, overflow=1.
- 0xFFFF0000 / 0x00000000 → 0x80000000, div_by_zero=1, overflow=0, same 49-edge latency. 0x00010000 / 0 → 0x7FFFFFFF.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0.
  - Operand changes during CALC → no effect.
  - Release out_ready → in_ready=1 next cycle.
- Assert rst_n low at step 20 of CALC → all outputs at reset values immediately. A subsequent 0xFFFF0000 / 0x00040000 gives 0xFFFFC000 with no stale result emitted.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions: divider FSM state type and signed saturation limits.
package fixed_point;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } fixed_point_div_state_t;

  // Largest positive two's-complement value of the given width (width <= 64).
  function automatic logic signed [63:0] sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative two's-complement value of the given width (width <= 64).
  function automatic logic signed [63:0] sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/fixed_point_div.sv
// Sequential signed fixed-point divider: restoring division on magnitudes, one quotient
// bit per cycle, then saturation and sign correction into the operand Q format.
module fixed_point_div
  import fixed_point::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned Q     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int unsigned NW   = WIDTH + Q;
  localparam int unsigned ITER = WIDTH + Q;
  localparam int unsigned CW   = $clog2(ITER + 1);

  localparam logic signed [63:0] MAX64 = sat_max(WIDTH);
  localparam logic signed [63:0] MIN64 = sat_min(WIDTH);
  localparam logic [WIDTH-1:0]   MAX_Q = MAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0]   MIN_Q = MIN64[WIDTH-1:0];
  // Magnitude limits: a negative result may reach one step further than a positive one.
  localparam logic [NW-1:0]      POS_LIM = NW'(MAX_Q);
  localparam logic [NW-1:0]      NEG_LIM = POS_LIM + 1'b1;

  fixed_point_div_state_t state;

  logic             sgn_a, sgn_b;
  logic [NW-1:0]    num;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [NW-1:0]    qmag;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic             neg;

  always_comb begin
    a_mag  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    b_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    rem_sh = {rem, num[NW-1]};
    ge     = rem_sh >= {1'b0, dvs};
    rem_nx = ge ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
    neg    = sgn_a ^ sgn_b;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sgn_a       <= 1'b0;
      sgn_b       <= 1'b0;
      num         <= '0;
      dvs         <= '0;
      rem         <= '0;
      qmag        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sgn_a <= dividend[WIDTH-1];
            sgn_b <= divisor[WIDTH-1];
            num   <= NW'(a_mag) << Q;
            dvs   <= b_mag;
            rem   <= '0;
            qmag  <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          num  <= num << 1;
          rem  <= rem_nx;
          qmag <= {qmag[NW-2:0], ge};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= FIX;
        end
        FIX: begin
          if (dvs == '0) begin
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
            quotient    <= sgn_a ? MIN_Q : MAX_Q;
          end else if (!neg && qmag > POS_LIM) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
            quotient    <= MAX_Q;
          end else if (neg && qmag > NEG_LIM) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
            quotient    <= MIN_Q;
          end else begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            quotient    <= neg ? (~qmag[WIDTH-1:0] + 1'b1) : qmag[WIDTH-1:0];
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_div.sv
// Scoreboard bench for fixed_point_div (WIDTH=32, Q=16) with hand-computed vectors.
module tb_fixed_point_div;

  typedef struct {
    logic [31:0] q;
    logic        ovf;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic prev_ov = 1'b0;

  exp_t exp_q[$];
  int   acc_q[$];

  fixed_point_div #(.WIDTH(32), .Q(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: latency on out_valid rise, result/flags on each output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else chk("latency", cyc - acc_q.pop_front(), 32'd49);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", quotient, 32'hDEADBEEF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("quotient", quotient, e.q);
          chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic ovf, input logic dbz);
    exp_t e;
    bit done;
    done = 1'b0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end else begin
      e.q = q; e.ovf = ovf; e.dbz = dbz;
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_flags", {30'd0, overflow, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h00018000, 32'h00008000, 32'h00030000, 1'b0, 1'b0);
    drain();
    issue(32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0);
    drain();
    issue(32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b0, 1'b0);
    drain();
    issue(32'h7FFF0000, 32'h00008000, 32'h7FFFFFFF, 1'b1, 1'b0);
    drain();
    issue(32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b1, 1'b0);
    drain();
    issue(32'hFFFF0000, 32'h00000000, 32'h80000000, 1'b0, 1'b1);
    drain();
    issue(32'h00010000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1);
    drain();
    issue(32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0);
    drain();

    // Backpressure with operand churn during CALC.
    out_ready = 1'b0;
    issue(32'h00030000, 32'hFFFE0000, 32'hFFFE8000, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    dividend = 32'h12345678;
    divisor  = 32'h00000001;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(posedge clk); #1;
        seen = out_valid;
      end
      if (!seen) chk("bp_valid_timeout", 32'd1, 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_quotient", quotient, 32'hFFFE8000);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset in the middle of CALC discards the operation.
    issue(32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_flags", {30'd0, overflow, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(32'hFFFF0000, 32'h00040000, 32'hFFFFC000, 1'b0, 1'b0);
    drain();
    repeat (60) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
